// File: rtl/cache_wb_buffer_if.sv
// Bus bundle for the write-back buffer: victim intake, memory write channel,
// lookup probe and occupancy status.
interface cache_wb_buffer_if #(
    parameter int LINE_BYTES = 64,
    parameter int BUS_BYTES  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                    evict_valid_i;
    logic                    evict_ready_o;
    logic                    evict_dirty_i;
    logic [ADDR_WIDTH-1:0]   evict_addr_i;
    logic [LINE_BYTES*8-1:0] evict_line_i;

    logic                    mem_aw_valid_o;
    logic                    mem_aw_ready_i;
    logic [ADDR_WIDTH-1:0]   mem_aw_addr_o;
    logic                    mem_w_valid_o;
    logic                    mem_w_ready_i;
    logic [BUS_BYTES*8-1:0]  mem_w_data_o;
    logic                    mem_w_last_o;
    logic                    mem_b_valid_i;
    logic                    mem_b_ready_o;

    logic [ADDR_WIDTH-1:0]   lookup_addr_i;
    logic                    lookup_hit_o;
    logic [CNT_W-1:0]        count_o;
    logic                    empty_o;

    // master is the buffer itself; slave is the cache/memory environment around it
    modport master (
        input  evict_valid_i, evict_dirty_i, evict_addr_i, evict_line_i,
        input  mem_aw_ready_i, mem_w_ready_i, mem_b_valid_i, lookup_addr_i,
        output evict_ready_o, mem_aw_valid_o, mem_aw_addr_o, mem_w_valid_o,
        output mem_w_data_o, mem_w_last_o, mem_b_ready_o, lookup_hit_o,
        output count_o, empty_o
    );

    modport slave (
        output evict_valid_i, evict_dirty_i, evict_addr_i, evict_line_i,
        output mem_aw_ready_i, mem_w_ready_i, mem_b_valid_i, lookup_addr_i,
        input  evict_ready_o, mem_aw_valid_o, mem_aw_addr_o, mem_w_valid_o,
        input  mem_w_data_o, mem_w_last_o, mem_b_ready_o, lookup_hit_o,
        input  count_o, empty_o
    );
endinterface

// File: rtl/cache_wb_buffer.sv
// Write-back buffer: queues dirty victim lines in a small FIFO and drains each
// as an address phase, a fixed data burst and a write response.
module cache_wb_buffer #(
    parameter int LINE_BYTES = 64,
    parameter int BUS_BYTES  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input logic               clk_i,
    input logic               rst_i,
    cache_wb_buffer_if.master bus
);
    localparam int BUS_BITS = BUS_BYTES * 8;
    localparam int BEATS    = LINE_BYTES / BUS_BYTES;
    localparam int OFF_W    = $clog2(LINE_BYTES);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] TAG_MASK  = {{(ADDR_WIDTH-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } state_e;

    state_e state_q;
    state_e state_d;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [BUS_BITS-1:0]   data_q [DEPTH][BEATS];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [CNT_W-1:0]      count_q;
    logic [BEAT_W-1:0]     beat_q;

    logic full;
    logic enq_fire;
    logic free_fire;
    logic aw_fire;
    logic w_fire;
    logic last_fire;

    logic aw_valid;
    logic w_valid;
    logic w_last;
    logic b_ready;
    logic hit;

    assign full      = (count_q == FULL_CNT);
    assign enq_fire  = bus.evict_valid_i & ~full & bus.evict_dirty_i;
    assign free_fire = (state_q == RESP) & bus.mem_b_valid_i;
    assign aw_fire   = (state_q == ADDR) & bus.mem_aw_ready_i;
    assign w_fire    = (state_q == DATA) & bus.mem_w_ready_i;
    assign last_fire = w_fire & (beat_q == LAST_BEAT);

    // Line storage is split into beats up front so the drain side is a plain index.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            addr_q[tail_q] <= bus.evict_addr_i & TAG_MASK;
            for (int b = 0; b < BEATS; b++) begin
                data_q[tail_q][b] <= bus.evict_line_i[b*BUS_BITS +: BUS_BITS];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq_fire) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_W'(1);
            end
            if (free_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_W'(1);
            end
            case ({enq_fire, free_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat counter restarts on every address handshake and wraps after the last beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (aw_fire) begin
            beat_q <= '0;
        end else if (w_fire) begin
            beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (count_q != '0) state_d = ADDR;
            ADDR: if (aw_fire)       state_d = DATA;
            DATA: if (last_fire)     state_d = RESP;
            RESP: if (free_fire)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        aw_valid = 1'b0;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        b_ready  = 1'b0;
        case (state_q)
            ADDR: aw_valid = 1'b1;
            DATA: begin
                w_valid = 1'b1;
                w_last  = (beat_q == LAST_BEAT);
            end
            RESP: b_ready = 1'b1;
            default: ;
        endcase
    end

    // The head stays valid until its response, so in-flight lines keep hitting.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == (bus.lookup_addr_i & TAG_MASK))) begin
                hit = 1'b1;
            end
        end
    end

    assign bus.evict_ready_o  = ~full;
    assign bus.mem_aw_valid_o = aw_valid;
    assign bus.mem_aw_addr_o  = addr_q[head_q];
    assign bus.mem_w_valid_o  = w_valid;
    assign bus.mem_w_data_o   = data_q[head_q][beat_q];
    assign bus.mem_w_last_o   = w_last;
    assign bus.mem_b_ready_o  = b_ready;
    assign bus.lookup_hit_o   = hit;
    assign bus.count_o        = count_q;
    assign bus.empty_o        = (count_q == '0);

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Self-checking bench for cache_wb_buffer: directed corner cases, a lookup vector
// table and randomized traffic checked against a queue-based line model.
module tb_cache_wb_buffer;
    localparam int LINE_BYTES = 64;
    localparam int BUS_BYTES  = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DEPTH      = 2;
    localparam int BEATS      = LINE_BYTES / BUS_BYTES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cache_wb_buffer_if #(
        .LINE_BYTES(LINE_BYTES), .BUS_BYTES(BUS_BYTES),
        .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
    ) bus ();

    cache_wb_buffer #(
        .LINE_BYTES(LINE_BYTES), .BUS_BYTES(BUS_BYTES),
        .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [511:0] line;
    } entry_t;

    typedef struct {
        logic [31:0] probe;
        logic        expHit;
    } probe_vec_t;

    entry_t      mq[$];
    logic [31:0] capAw[$];
    logic [63:0] capBeat[$];
    logic        capLast[$];

    int          checks = 0;
    int          failures = 0;
    bit          inBurst;
    bit          respPending;
    int          beatIdx;
    bit          prevAwStall;
    logic [31:0] prevAwAddr;
    bit          lastEnq;
    bit          lastFree;

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFC0;
    endfunction

    function automatic logic [511:0] incLine(input int base);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[i*8 +: 8] = 8'(base + i);
        return l;
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic dirty, input logic [31:0] addr,
                                 input logic [511:0] line, input logic awr, input logic wr,
                                 input logic bv, input logic [31:0] probe);
        bus.evict_valid_i  = ev;
        bus.evict_dirty_i  = dirty;
        bus.evict_addr_i   = addr;
        bus.evict_line_i   = line;
        bus.mem_aw_ready_i = awr;
        bus.mem_w_ready_i  = wr;
        bus.mem_b_valid_i  = bv;
        bus.lookup_addr_i  = probe;
    endtask

    task automatic clearModel();
        mq.delete();
        inBurst     = 0;
        respPending = 0;
        beatIdx     = 0;
        prevAwStall = 0;
        lastEnq     = 0;
        lastFree    = 0;
    endtask

    task automatic clearCaptures();
        capAw.delete();
        capBeat.delete();
        capLast.delete();
    endtask

    // Compares every observable output against what the line queue implies.
    task automatic checkOutput();
        bit expHit;
        bit awAllowed;
        expHit = 0;
        foreach (mq[i]) if (mq[i].addr == align(bus.lookup_addr_i)) expHit = 1;
        awAllowed = !inBurst && !respPending && (mq.size() != 0);
        check("evict_ready", bus.evict_ready_o, mq.size() != DEPTH);
        check("count", bus.count_o, mq.size());
        check("empty", bus.empty_o, mq.size() == 0);
        check("lookup_hit", bus.lookup_hit_o, expHit);
        check("b_ready", bus.mem_b_ready_o, respPending);
        check("w_valid", bus.mem_w_valid_o, inBurst);
        check("aw_valid_illegal", bus.mem_aw_valid_o && !awAllowed, 0);
        if (prevAwStall) begin
            check("aw_hold", bus.mem_aw_valid_o, 1);
            check("aw_addr_hold", bus.mem_aw_addr_o, prevAwAddr);
        end
        if (bus.mem_aw_valid_o && awAllowed) check("aw_addr", bus.mem_aw_addr_o, mq[0].addr);
        if (bus.mem_w_valid_o && inBurst) begin
            check("w_data", bus.mem_w_data_o, mq[0].line[beatIdx*64 +: 64]);
            check("w_last", bus.mem_w_last_o, beatIdx == BEATS - 1);
        end
    endtask

    task automatic modelUpdate();
        bit expReady;
        bit awFire;
        bit wFire;
        expReady = (mq.size() != DEPTH);
        lastEnq  = bus.evict_valid_i && expReady;
        lastFree = respPending && bus.mem_b_valid_i;
        awFire   = bus.mem_aw_valid_o && bus.mem_aw_ready_i && !inBurst && !respPending;
        wFire    = inBurst && bus.mem_w_ready_i;
        prevAwStall = bus.mem_aw_valid_o && !bus.mem_aw_ready_i;
        prevAwAddr  = bus.mem_aw_addr_o;
        if (lastFree) begin
            void'(mq.pop_front());
            respPending = 0;
        end
        if (wFire) begin
            capBeat.push_back(bus.mem_w_data_o);
            capLast.push_back(bus.mem_w_last_o);
            beatIdx++;
            if (beatIdx == BEATS) begin
                inBurst     = 0;
                respPending = 1;
            end
        end
        if (awFire) begin
            capAw.push_back(bus.mem_aw_addr_o);
            inBurst = 1;
            beatIdx = 0;
        end
        if (lastEnq && bus.evict_dirty_i) mq.push_back('{align(bus.evict_addr_i), bus.evict_line_i});
    endtask

    task automatic tick();
        #1;
        if (rst) begin
            clearModel();
        end else begin
            checkOutput();
            modelUpdate();
        end
        @(negedge clk);
    endtask

    task automatic waitDrain(input int limit, input string name);
        int n = 0;
        while (mq.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("[TB] FAIL %s drain timeout actual=%0d expected=0 entries", name, mq.size());
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        probe_vec_t vecs[6];
        int n;
        logic [511:0] rline;
        logic [31:0]  raddr;

        vecs[0] = '{32'h0000_403C, 1'b1};
        vecs[1] = '{32'h0000_4040, 1'b0};
        vecs[2] = '{32'h0000_4000, 1'b1};
        vecs[3] = '{32'h0000_3FFC, 1'b0};
        vecs[4] = '{32'h0000_403F, 1'b1};
        vecs[5] = '{32'h8000_4000, 1'b0};

        clearModel();
        clearCaptures();
        applyStimulus(0, 0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        #1;
        check("rst_count", bus.count_o, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_ready", bus.evict_ready_o, 1);
        check("rst_aw_valid", bus.mem_aw_valid_o, 0);
        check("rst_w_valid", bus.mem_w_valid_o, 0);
        check("rst_b_ready", bus.mem_b_ready_o, 0);

        $display("[TB] single dirty victim");
        clearCaptures();
        applyStimulus(1, 1, 32'h0000_1234, incLine(0), 1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, '0, 1, 1, 1, 0);
        waitDrain(50, "t1");
        check("t1_aw_count", capAw.size(), 1);
        check("t1_aw_addr", capAw[0], 32'h0000_1200);
        check("t1_beat_count", capBeat.size(), 8);
        check("t1_beat0", capBeat[0], 64'h0706_0504_0302_0100);
        check("t1_beat7", capBeat[7], 64'h3F3E_3D3C_3B3A_3938);
        check("t1_last6", capLast[6], 0);
        check("t1_last7", capLast[7], 1);
        #1;
        check("t1_empty", bus.empty_o, 1);

        $display("[TB] clean victim");
        clearCaptures();
        applyStimulus(1, 0, 32'h0000_2000, incLine(8'h40), 1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, '0, 1, 1, 1, 0);
        repeat (10) tick();
        #1;
        check("t2_count", bus.count_o, 0);
        check("t2_aw_seen", capAw.size(), 0);

        $display("[TB] fill and stall");
        clearCaptures();
        applyStimulus(1, 1, 32'h0000_3000, incLine(8'h10), 0, 1, 1, 0);
        tick();
        applyStimulus(1, 1, 32'h0000_3040, incLine(8'h20), 0, 1, 1, 0);
        tick();
        applyStimulus(1, 1, 32'h0000_3080, incLine(8'h30), 0, 1, 1, 0);
        repeat (4) tick();
        #1;
        check("t3_full_ready", bus.evict_ready_o, 0);
        check("t3_full_count", bus.count_o, 2);
        bus.mem_aw_ready_i = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!lastEnq && n < 60);
        check("t3_third_accept_cycles_ok", n < 60, 1);
        applyStimulus(0, 0, 0, '0, 1, 1, 1, 0);
        waitDrain(100, "t3");
        check("t3_aw_count", capAw.size(), 3);
        check("t3_aw0", capAw[0], 32'h0000_3000);
        check("t3_aw1", capAw[1], 32'h0000_3040);
        check("t3_aw2", capAw[2], 32'h0000_3080);

        $display("[TB] lookup table");
        applyStimulus(1, 1, 32'h0000_4000, incLine(8'h80), 0, 1, 0, 32'h0000_403C);
        tick();
        bus.evict_valid_i = 0;
        foreach (vecs[i]) begin
            bus.lookup_addr_i = vecs[i].probe;
            #1;
            check("lookup_tbl", bus.lookup_hit_o, vecs[i].expHit);
            tick();
        end
        bus.lookup_addr_i  = 32'h0000_403C;
        bus.mem_aw_ready_i = 1;
        n = 0;
        while (!bus.mem_b_ready_o && n < 50) begin
            tick();
            n++;
        end
        repeat (3) begin
            #1;
            check("t5_hit_resp", bus.lookup_hit_o, 1);
            tick();
        end
        bus.mem_b_valid_i = 1;
        tick();
        #1;
        check("t5_hit_after_b", bus.lookup_hit_o, 0);
        check("t5_count_after_b", bus.count_o, 0);

        $display("[TB] reset mid-burst");
        clearCaptures();
        applyStimulus(1, 1, 32'h0000_5000, incLine(8'hA0), 1, 1, 0, 0);
        tick();
        bus.evict_valid_i = 0;
        n = 0;
        while (capBeat.size() < 3 && n < 40) begin
            tick();
            n++;
        end
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("t6_aw_valid", bus.mem_aw_valid_o, 0);
        check("t6_w_valid", bus.mem_w_valid_o, 0);
        check("t6_b_ready", bus.mem_b_ready_o, 0);
        check("t6_count", bus.count_o, 0);
        check("t6_ready", bus.evict_ready_o, 1);
        clearCaptures();
        applyStimulus(1, 1, 32'h0000_6000, incLine(8'hC0), 1, 1, 1, 0);
        tick();
        applyStimulus(0, 0, 0, '0, 1, 1, 1, 0);
        waitDrain(50, "t6");
        check("t6_aw_addr", capAw[0], 32'h0000_6000);
        check("t6_beat_count", capBeat.size(), 8);
        check("t6_beat0", capBeat[0], 64'hC7C6_C5C4_C3C2_C1C0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 16; k++) rline[k*32 +: 32] = $urandom;
            raddr = 32'h0001_0000 | ($urandom_range(0, 5) << 6) | $urandom_range(0, 63);
            applyStimulus($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 75, raddr, rline,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          32'h0001_0000 | ($urandom_range(0, 5) << 6) | $urandom_range(0, 63));
            tick();
        end
        applyStimulus(0, 0, 0, '0, 1, 1, 1, 0);
        waitDrain(100, "rand");
        #1;
        check("rand_empty", bus.empty_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
